// File: rtl/mux_pkg.sv
// Shared constants and width helpers for the registered N-to-1 multiplexer.
// The optional round-robin mode is selected with the MUX_NTO1_RR_EN macro.
package mux_pkg;

  // Width of the delivered-beat counter.
  localparam int XFER_CNT_W = 16;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 32'sd0;
    v   = value - 32'sd1;
    while (v > 32'sd0) begin
      res = res + 32'sd1;
      v   = v >>> 32'sd1;
    end
    return res;
  endfunction

  // Select width: at least one bit even for degenerate channel counts.
  function automatic int sel_width(input int n);
    return (clog2(n) < 32'sd1) ? 32'sd1 : clog2(n);
  endfunction

endpackage

// File: rtl/mux_nto1_reg_rr_pick.sv
// Round-robin grant picker: first valid channel scanning upward from p with wrap.
// Only compiled when MUX_NTO1_RR_EN is defined, the only build that uses it.
`ifdef MUX_NTO1_RR_EN
module rr_pick
  import mux_pkg::*;
#(
  parameter int channels = 4,
  parameter int SEL_W    = sel_width(channels)
) (
  input  logic [channels-1:0] valid,
  input  logic [SEL_W-1:0]    p,
  output logic [SEL_W-1:0]    g,
  output logic                any_valid
);

  // Priority scan p, p+1, ..., channels-1, 0, ..., p-1; first hit wins.
  always_comb begin
    int idx;
    g         = {SEL_W{1'b0}};
    any_valid = 1'b0;
    idx       = 32'sd0;
    for (int i = 0; i < channels; i++) begin
      idx = int'(p) + i;
      if (idx >= channels) begin
        idx = idx - channels;
      end else begin
        idx = idx;
      end
      if (!any_valid && (idx < channels) && valid[idx]) begin
        any_valid = 1'b1;
        g         = SEL_W'(idx);
      end else begin
        any_valid = any_valid;
      end
    end
  end

endmodule
`endif

// File: rtl/mux_nto1_reg.sv
// Registered N-to-1 data multiplexer with per-channel valid/ready handshake,
// a one-entry output register and a wrapping delivered-beat counter.
// Define MUX_NTO1_RR_EN to replace explicit select_i with round-robin grant.
module mux_nto1_reg
  import mux_pkg::*;
#(
  parameter int size     = 32,
  parameter int channels = 4,
  parameter int SEL_W    = sel_width(channels)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [channels*size-1:0] data_i,
  input  logic [channels-1:0]      valid_i,
  output logic [channels-1:0]      ready_o,
  input  logic [SEL_W-1:0]         select_i,
  output logic [size-1:0]          data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [SEL_W-1:0]         sel_o,
  output logic [XFER_CNT_W-1:0]    xfer_cnt_o
);

  logic [size-1:0]       data_r;
  logic [SEL_W-1:0]      sel_r;
  logic                  valid_r;
  logic [XFER_CNT_W-1:0] cnt_r;

  logic                  load_en_s;
  logic                  drain_s;
  logic                  accept_s;
  logic                  grant_ok_s;
  logic [SEL_W-1:0]      grant_s;
  logic [size-1:0]       data_sel_s;

  // Register may load when empty or when it is being drained this cycle.
  assign load_en_s = !valid_r || ready_i;
  assign drain_s   = valid_r && ready_i;

`ifdef MUX_NTO1_RR_EN
  logic [SEL_W-1:0] ptr_r;
  logic [SEL_W-1:0] pick_s;
  logic             any_s;
  logic             unused_select_s;

  // select_i is kept on the port list for drop-in compatibility only.
  assign unused_select_s = ^select_i;

  rr_pick #(
    .channels (channels),
    .SEL_W    (SEL_W)
  ) u_rr_pick (
    .valid     (valid_i),
    .p         (ptr_r),
    .g         (pick_s),
    .any_valid (any_s)
  );

  assign grant_s    = pick_s;
  assign grant_ok_s = any_s;

  // Pointer advances past the granted channel only when a beat is taken.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_r <= {SEL_W{1'b0}};
    end else if (accept_s) begin
      ptr_r <= (grant_s == SEL_W'(channels - 1)) ? {SEL_W{1'b0}} : grant_s + SEL_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  assign grant_s    = select_i;
  assign grant_ok_s = (int'(select_i) < channels);
`endif

  // One-hot ready on the granted channel; never asserted during reset.
  always_comb begin
    ready_o = {channels{1'b0}};
    for (int k = 0; k < channels; k++) begin
      if (rst_i && grant_ok_s && load_en_s && (grant_s == SEL_W'(k))) begin
        ready_o[k] = 1'b1;
      end else begin
        ready_o[k] = 1'b0;
      end
    end
  end

  // Data slice of the granted channel; zero when the grant is out of range.
  always_comb begin
    data_sel_s = {size{1'b0}};
    for (int k = 0; k < channels; k++) begin
      if (grant_s == SEL_W'(k)) begin
        data_sel_s = data_i[k*size +: size];
      end else begin
        data_sel_s = data_sel_s;
      end
    end
  end

  assign accept_s = |(valid_i & ready_o);

  // Output register: load on accept, empty on bare drain, hold under stall.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_r  <= {size{1'b0}};
      sel_r   <= {SEL_W{1'b0}};
      valid_r <= 1'b0;
    end else if (accept_s) begin
      data_r  <= data_sel_s;
      sel_r   <= grant_s;
      valid_r <= 1'b1;
    end else if (drain_s) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Count every beat the consumer takes; wraps naturally at full scale.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_r <= {XFER_CNT_W{1'b0}};
    end else if (drain_s) begin
      cnt_r <= cnt_r + XFER_CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign data_o     = data_r;
  assign sel_o      = sel_r;
  assign valid_o    = valid_r;
  assign xfer_cnt_o = cnt_r;

endmodule
